// File: rtl/des_perm_pkg.sv
// Shared constants and helpers for the parametrised DES bit-permutation pipe.
// Contents: width/depth limits, the zero-based DES straight P-box table, and
// an identity-map generator used as the reset map for non-32-bit builds.
package des_perm_pkg;

   localparam int unsigned W_MAX      = 64;
   localparam int unsigned STAGES_MAX = 4;
   localparam int unsigned IDX_MAX_W  = 6;

   // DES P-box, zero-based: output bit j takes input bit DES_P_MAP[j].
   localparam logic [4:0] DES_P_MAP [32] = '{
      5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
      5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
      5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
      5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
   };

   // Entry i holds i for i < w; unused upper entries are zero.
   function automatic logic [W_MAX-1:0][IDX_MAX_W-1:0] identity_map(input int unsigned w);
      logic [W_MAX-1:0][IDX_MAX_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < W_MAX; i++) begin
         if (i < w) m[i] = IDX_MAX_W'(i);
      end
      return m;
   endfunction

endpackage

// File: rtl/des_perm_pipe_stage.sv
// perm_pipe_stage: one elastic register stage with its own valid bit.
// Ports: up_valid/up_ready_c/up_data (upstream side, ready is combinational),
//        down_valid/down_ready/down_data (downstream side, registered).
// The stage loads when empty or when its current word leaves this cycle.
module perm_pipe_stage #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   output logic         up_ready_c,
   input  logic [W-1:0] up_data,
   output logic         down_valid,
   input  logic         down_ready,
   output logic [W-1:0] down_data
);

   logic         v_q;
   logic [W-1:0] d_q;
   logic         adv_c;
   logic         load_c;

   assign adv_c      = v_q & down_ready;
   assign up_ready_c = ~v_q | adv_c;
   assign load_c     = up_valid & up_ready_c;

   // Valid/data register; a load wins over a simultaneous advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else if (load_c) begin
         v_q <= 1'b1;
         d_q <= up_data;
      end else if (adv_c) begin
         v_q <= 1'b0;
      end
   end

   assign down_valid = v_q;
   assign down_data  = d_q;

endmodule

// File: rtl/des_perm_pipe.sv
// des_perm_pipe: run-time-loadable W-bit permutation with a STAGES-deep
// elastic valid/ready pipeline. Forward rule: out[j] = in[map[j]].
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data (input
// handshake); out_valid/out_ready/out_data (output handshake);
// cfg_wr/cfg_dst/cfg_src (writes map[cfg_dst] <= cfg_src);
// inv_mode (inverse/scatter select, only when PERM_INVERSE_EN is defined).
// Optional feature macro: PERM_INVERSE_EN.
module des_perm_pipe
   import des_perm_pkg::*;
#(
   parameter  int unsigned W      = 32,
   parameter  int unsigned STAGES = 2,
   localparam int unsigned IDX_W  = $clog2(W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   input  logic             cfg_wr,
   input  logic [IDX_W-1:0] cfg_dst,
`ifdef PERM_INVERSE_EN
   input  logic [IDX_W-1:0] cfg_src,
   input  logic             inv_mode
`else
   input  logic [IDX_W-1:0] cfg_src
`endif
);

   // Index space rounded up to a power of two; positions >= W read as 0,
   // which makes out-of-range map entries drive 0 without extra compares.
   localparam int unsigned WP = 1 << IDX_W;
   localparam logic [W_MAX-1:0][IDX_MAX_W-1:0] ID_MAP = identity_map(W);

   function automatic logic [IDX_W-1:0] map_reset(input int unsigned j);
      logic [4:0] jj;
      jj = 5'(j);
      if (W == 32) return IDX_W'(DES_P_MAP[jj]);
      return IDX_W'(ID_MAP[j]);
   endfunction

   logic [IDX_W-1:0] map_q [W];
   logic [WP-1:0]    in_ext;
   logic [W-1:0]     fwd_c;
   logic [W-1:0]     perm_c;

   // Map register file; a dst >= W matches no entry and is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < W; j++) map_q[j] <= map_reset(j);
      end else if (cfg_wr) begin
         for (int unsigned j = 0; j < W; j++) begin
            if (cfg_dst == IDX_W'(j)) map_q[j] <= cfg_src;
         end
      end
   end

   assign in_ext = WP'(in_data);

   // Forward gather.
   always_comb begin
      fwd_c = '0;
      for (int unsigned j = 0; j < W; j++) fwd_c[j] = in_ext[map_q[j]];
   end

`ifdef PERM_INVERSE_EN
   logic [WP-1:0] inv_ext;

   // Inverse scatter: in[j] is ORed into position map[j]; unsourced bits stay 0.
   always_comb begin
      inv_ext = '0;
      for (int unsigned j = 0; j < W; j++) inv_ext[map_q[j]] = inv_ext[map_q[j]] | in_data[j];
   end

   assign perm_c = inv_mode ? inv_ext[W-1:0] : fwd_c;
`else
   assign perm_c = fwd_c;
`endif

   // Elastic pipeline; stage 0 captures the permuted word at accept.
   for (genvar g = 0; g < STAGES; g++) begin : stg
      logic         up_v;
      logic         up_r_c;
      logic [W-1:0] up_d;
      logic         dn_v;
      logic         dn_r;
      logic [W-1:0] dn_d;

      if (g == 0) begin : g_first
         assign up_v = in_valid;
         assign up_d = perm_c;
      end else begin : g_mid
         assign up_v = stg[g-1].dn_v;
         assign up_d = stg[g-1].dn_d;
      end

      if (g == STAGES - 1) begin : g_last
         assign dn_r = out_ready;
      end else begin : g_inner
         assign dn_r = stg[g+1].up_r_c;
      end

      perm_pipe_stage #(.W(W)) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .up_valid   (up_v),
         .up_ready_c (up_r_c),
         .up_data    (up_d),
         .down_valid (dn_v),
         .down_ready (dn_r),
         .down_data  (dn_d)
      );
   end

   assign in_ready  = stg[0].up_r_c;
   assign out_valid = stg[STAGES-1].dn_v;
   assign out_data  = stg[STAGES-1].dn_d;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Self-checking bench for des_perm_pipe (W=32, STAGES=2) with a scoreboard
// driven by a bit-level model of the permutation map.
module tb_des_perm_pipe;

   localparam int unsigned W      = 32;
   localparam int unsigned STAGES = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, cfg_wr, inv_mode;
   logic [31:0] in_data, out_data;
   logic [4:0]  cfg_dst, cfg_src;

   always #5 clk = ~clk;

   des_perm_pipe #(.W(W), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cfg_wr    (cfg_wr),
      .cfg_dst   (cfg_dst),
`ifdef PERM_INVERSE_EN
      .cfg_src   (cfg_src),
      .inv_mode  (inv_mode)
`else
      .cfg_src   (cfg_src)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int stalls   = 0;
   int npop     = 0;
   int cyc      = 0;
   bit rnd_bp   = 1'b0;
   int pop_cyc [$];
   logic [31:0] expq [$];

   // DES P table as printed in the standard (one-based).
   int unsigned p1 [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                            2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
   int unsigned mmap [32];

   function automatic void model_reset();
      for (int j = 0; j < 32; j++) mmap[j] = p1[j] - 1;
   endfunction

   function automatic logic [31:0] model_perm(input logic [31:0] x, input logic inv);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 32; j++) begin
         if (mmap[j] < 32) begin
            if (inv) r[mmap[j]] = r[mmap[j]] | x[j];
            else     r[j] = x[mmap[j]];
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Scoreboard: sampled mid-cycle, describes the transfers of the next edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         expq.delete();
         model_reset();
      end else begin
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
               check("stream_data", out_data, expq.pop_front());
            end
            npop++;
            pop_cyc.push_back(cyc);
         end
         if (in_valid && in_ready) expq.push_back(model_perm(in_data, inv_mode));
         if (cfg_wr) mmap[cfg_dst] = 32'(cfg_src);
      end
   end

   // All driving tasks start and end shortly after a rising edge.
   task automatic send(input logic [31:0] d, input logic wr = 1'b0,
                       input logic [4:0] dst = 5'd0, input logic [4:0] src = 5'd0);
      in_valid = 1'b1;
      in_data  = d;
      cfg_wr   = wr;
      cfg_dst  = dst;
      cfg_src  = src;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (in_ready) break;
         if (t == 0) stalls++;
         if (t > 100) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      cfg_wr   = 1'b0;
   endtask

   task automatic cfg_write(input logic [4:0] dst, input logic [4:0] src);
      cfg_wr  = 1'b1;
      cfg_dst = dst;
      cfg_src = src;
      @(posedge clk);
      #2;
      cfg_wr = 1'b0;
   endtask

   task automatic get_out(output logic [31:0] v, output int lat);
      lat = 0;
      v   = '0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         lat++;
         if (out_valid) begin
            v = out_data;
            break;
         end
      end
      if (!out_valid) check("get_out_timeout", 32'(out_valid), 32'd1);
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (expq.size() == 0 && !out_valid) break;
      end
      check("drain_empty", 32'(expq.size()), 32'd0);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v, y, z, x;
      int lat, p0;

      model_reset();
      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      cfg_wr = 1'b0; cfg_dst = '0; cfg_src = '0; inv_mode = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", out_data, 32'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Default DES P map, literal results and latency.
      send(32'h0000_8000);
      get_out(v, lat);
      check("p_bit15", v, 32'h0000_0001);
      check("latency", 32'(lat), 32'(STAGES));
      send(32'h0000_0001);
      get_out(v, lat);
      check("p_bit0", v, 32'h0000_0100);

      // Back-to-back streaming.
      stalls = 0; p0 = npop; pop_cyc.delete();
      for (int i = 0; i < 16; i++) send($urandom);
      drain();
      check("stream_stalls", 32'(stalls), 32'd0);
      check("stream_count", 32'(npop - p0), 32'd16);
      check("stream_span", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[0]), 32'd15);

      // Backpressure: two words held, third refused until release.
      p0 = npop;
      out_ready = 1'b0;
      fork
         begin
            send(32'h1111_1111);
            send(32'h2222_2222);
            send(32'h4444_4444);
         end
      join_none
      repeat (5) @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #2 out_ready = 1'b1;
      wait fork;
      drain();
      check("bp_count", 32'(npop - p0), 32'd3);

      // Map writes and same-cycle write ordering.
      cfg_write(5'd0, 5'd31);
      send(32'h8000_0000);
      get_out(v, lat);
      check("cfg_new_map", v, 32'h0010_0001);
      send(32'h8000_0000, 1'b1, 5'd0, 5'd0);
      get_out(v, lat);
      check("cfg_same_cycle_old", v, 32'h0010_0001);
      send(32'h8000_0000);
      get_out(v, lat);
      check("cfg_after_write", v, 32'h0010_0000);

      // Random map writes, random traffic and random backpressure.
      rnd_bp = 1'b1;
      fork
         while (rnd_bp) begin
            @(posedge clk);
            #2 out_ready = ($urandom_range(0, 2) != 0);
         end
      join_none
      for (int i = 0; i < 60; i++) begin
`ifdef PERM_INVERSE_EN
         inv_mode = ($urandom_range(0, 1) != 0);
`endif
         if ($urandom_range(0, 3) == 0) cfg_write(5'($urandom), 5'($urandom));
         else send($urandom, ($urandom_range(0, 4) == 0), 5'($urandom), 5'($urandom));
      end
      rnd_bp = 1'b0;
      inv_mode = 1'b0;
      @(posedge clk);
      #3 out_ready = 1'b1;
      drain();

      // Reset with two words in flight.
      out_ready = 1'b0;
      send(32'hdead_beef);
      send(32'h0bad_f00d);
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_out_data", out_data, 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("postreset_in_ready", 32'(in_ready), 32'd1);
      check("postreset_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      send(32'h0000_8000);
      get_out(v, lat);
      check("map_restored", v, 32'h0000_0001);

`ifdef PERM_INVERSE_EN
      inv_mode = 1'b1;
      send(32'h0000_0001);
      get_out(v, lat);
      check("inv_bit0", v, 32'h0000_8000);
      for (int i = 0; i < 8; i++) begin
         x = $urandom;
         inv_mode = 1'b0;
         send(x);
         get_out(y, lat);
         inv_mode = 1'b1;
         send(y);
         get_out(z, lat);
         check("inv_roundtrip", z, x);
      end
      inv_mode = 1'b0;
`endif
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
- Parametrised successor to the fixed 32-bit DES straight P-box.
- Applies a run-time-loadable bit permutation to a W-bit word.
- Uses a STAGES-deep elastic pipeline with valid/ready handshake on input and output.
- Sits in the f-block datapath after the S-box stage; the same unit also serves the other DES bit permutations (IP/FP, at W=64).

Parameters:
- W, 32, data width in bits; legal range 2..64.
- IDX_W, $clog2(W), width of a bit index; derived, not overridden.
- STAGES, 2, number of pipeline register stages; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  unit accepts the input word this cycle.
- in_data  in  W  input word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  W  permuted word.
- cfg_wr  in  1  write one permutation-map entry.
- cfg_dst  in  IDX_W  output bit position being programmed.
- cfg_src  in  IDX_W  input bit index that drives position cfg_dst.
- inv_mode  in  1  inverse permutation select; present only with PERM_INVERSE_EN.

Behaviour:
- Map: W entries of IDX_W bits. Forward rule: out[j] = in[map[j]].
- Map reset value at W=32: zero-based DES P table (map[0]=15, map[1]=6, map[2]=19, map[3]=20, ..., map[31]=24). At any other W: identity.
- Permutation is computed combinationally at the accept edge (in_valid && in_ready). Stage 1 captures the permuted word. Later stages are pure elastic registers.
- Each stage has its own valid bit. A stage loads when it is empty or when its contents advance in the same cycle.
- in_ready = !v[1] || stage 1 advances. out_valid = v[STAGES]. out_data = data[STAGES].
- Latency: STAGES cycles from accept to out_valid when out_ready is held high.
- Throughput: one word per cycle. No bubbles under continuous flow. No combinational path from out_ready to in_ready beyond the stage-advance chain.
- Under backpressure, up to STAGES words are held. Order is preserved; nothing is dropped or duplicated.
- cfg_wr writes map[cfg_dst] <= cfg_src. The write is legal at any time.
  - A word accepted in the same cycle as a write uses the old map.
  - Words already in flight are unaffected.
  - cfg_dst >= W: write ignored.
  - cfg_src >= W: the entry drives 0.
- A non-bijective map is legal. Forward mode simply duplicates or drops bits.
- Reset (asynchronous, any time, including mid-transfer):
  - all v <= 0; out_valid = 0 and in_ready = 1 once reset is released;
  - all data registers <= 0; out_data = 0;
  - map restored to its reset value;
  - in-flight words are discarded.

Optional Feature:
- Macro: PERM_INVERSE_EN.
- Defined: inv_mode port exists, sampled with each accepted word and carried with it.
  - When inv_mode=1, out[k] = OR of in[j] over all j with map[j]==k.
  - Output bits with no source are 0.
  - For a bijective map, this is the exact inverse of forward mode.
- Undefined: inv_mode port absent; forward mode only; no scatter logic synthesised.

Decomposition:
- Package des_perm_pkg holds:
  - constant DES_P_MAP (32 x 5-bit, zero-based);
  - function identity_map(W);
  - localparam limits W_MAX=64 and STAGES_MAX=4.
- Sub-module perm_pipe_stage: one elastic register stage (valid, data, ready-chain).
- The top instantiates STAGES copies of perm_pipe_stage. The map register file and permute logic stay in the top.

Test Plan:
- Reset defaults, W=32, STAGES=2: in_data 0x0000_8000 -> out_data 0x0000_0001 exactly 2 cycles after accept. in_data 0x0000_0001 -> 0x0000_0100.
- Streaming: 16 back-to-back random words with out_ready=1 -> in_ready constantly 1, outputs match the DES P model, one word per cycle.
- Backpressure: out_ready=0 for 5 cycles while driving 3 words -> in_ready falls after 2 held words. On release, all 3 emerge in order with no loss.
- Config: cfg_wr dst=0 src=31, then send 0x8000_0000 -> 0x0010_0001. A word accepted in the write cycle itself uses the old map.
- Reset mid-flight: pull rst_n low with 2 words in the pipe -> out_valid=0 immediately. After release, 0x0000_8000 -> 0x0000_0001, confirming the map was restored.
- With PERM_INVERSE_EN, default map: inv_mode=1, in 0x0000_0001 -> 0x0000_8000. Forward then inverse of random words round-trips exactly.
